// File: rtl/rle_frame_arbiter.sv
// rtl/rle_frame_arbiter.sv - frame-granular round-robin arbiter sharing one RLE kernel between two pixel sources
module rle_frame_arbiter #(
  parameter int WIDTH        = 16,
  parameter int PIXEL_COUNT  = 1600,
  parameter int DRAIN_CYCLES = 8,
  parameter int HDR_EN       = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_avail,
  output logic             in0_read,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_avail,
  output logic             in1_read,
  output logic [WIDTH-1:0] k_input,
  output logic             k_avail,
  input  logic             k_read,
  input  logic [WIDTH-1:0] k_output,
  input  logic             k_write,
  output logic             k_afull,
  output logic [WIDTH-1:0] out_data,
  output logic             out_write,
  input  logic             out_afull,
  output logic             grant,
  output logic             busy,
  output logic             frame_done
);

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_STREAM, ST_DRAIN} state_e;

  localparam logic [15:0] PIX_LAST   = 16'(PIXEL_COUNT - 1);
  localparam logic [15:0] QUIET_LAST = 16'(DRAIN_CYCLES - 1);

  state_e      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic [15:0] pix_cnt_q, pix_cnt_d;
  logic [15:0] quiet_cnt_q, quiet_cnt_d;

  logic [1:0]       avail_v;
  logic [WIDTH-1:0] hdr_word;

  assign avail_v = {in1_avail, in0_avail};

  // Header: 0xA5 in the top byte, granted channel in bit 0.
  always_comb begin
    hdr_word                 = '0;
    hdr_word[WIDTH-1 -: 8]   = 8'hA5;
    hdr_word[0]              = grant_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      pix_cnt_q    <= '0;
      quiet_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      pix_cnt_q    <= pix_cnt_d;
      quiet_cnt_q  <= quiet_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    pix_cnt_d    = pix_cnt_q;
    quiet_cnt_d  = quiet_cnt_q;
    in0_read     = 1'b0;
    in1_read     = 1'b0;
    k_input      = '0;
    k_avail      = 1'b0;
    out_data     = k_output;
    out_write    = k_write;
    k_afull      = out_afull;
    frame_done   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (avail_v[~last_grant_q] || avail_v[last_grant_q]) begin
          grant_d   = avail_v[~last_grant_q] ? ~last_grant_q : last_grant_q;
          pix_cnt_d = '0;
          state_d   = (HDR_EN != 0) ? ST_HDR : ST_STREAM;
        end
      end

      ST_HDR: begin
        // Kernel is held off the output port while the header goes out.
        k_afull   = 1'b1;
        out_data  = hdr_word;
        out_write = ~out_afull;
        if (!out_afull) begin
          state_d = ST_STREAM;
        end
      end

      ST_STREAM: begin
        k_input  = grant_q ? in1_data : in0_data;
        k_avail  = avail_v[grant_q];
        in0_read = ~grant_q & k_read;
        in1_read =  grant_q & k_read;
        if (k_read) begin
          pix_cnt_d = pix_cnt_q + 16'd1;
          if (pix_cnt_q == PIX_LAST) begin
            quiet_cnt_d = '0;
            state_d     = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        if (k_write) begin
          quiet_cnt_d = '0;
        end else if (!out_afull) begin
          quiet_cnt_d = quiet_cnt_q + 16'd1;
          if (quiet_cnt_q == QUIET_LAST) begin
            frame_done   = 1'b1;
            last_grant_d = grant_q;
            state_d      = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign grant = grant_q;
  assign busy  = (state_q != ST_IDLE);

endmodule
